// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bundle between instruction fetch, the
// immediate generator and the decode stage.
//   in_valid/in_ready/in_instr           : instruction beat into the block
//   out_valid/out_ready/out_imm/out_fmt/
//   out_illegal                          : decoded beat towards decode
// Modports: slave = the immediate generator, master = the surrounding logic.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate extractor with a one-entry skid buffer.
// Decodes the format of each accepted 32-bit instruction, emits the
// sign-extended XLEN-bit immediate, a format tag and an illegal flag, and keeps
// a saturating count of accepted illegal beats.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-high reset
//   bus         : imm_gen_pipe_if.slave (in_* beat in, out_* decoded beat out)
//   illegal_cnt : saturating count of accepted illegal beats
// Build option: define IMM_GEN_UJ_EN to decode U and J formats; otherwise
// their opcodes are reported as illegal.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  logic [31:0]     w_instr;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  fmt_t            w_fmt;
  logic            w_illegal;
  logic            w_accept;
  logic            w_drain;

  logic [XLEN-1:0] r_imm;
  fmt_t            r_fmt;
  logic            r_illegal;
  logic            r_out_valid;
  logic [XLEN-1:0] r_skid_imm;
  fmt_t            r_skid_fmt;
  logic            r_skid_illegal;
  logic            r_skid_valid;
  logic            r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  assign w_instr = bus.in_instr;

  // All immediates fit in 32 bits, so build them there and sign-extend once.
  always_comb begin
    w_imm32   = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        w_fmt   = FMT_I;
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      7'b0100011: begin
        w_fmt   = FMT_S;
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end
      7'b1100011: begin
        w_fmt   = FMT_B;
        w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                   w_instr[30:25], w_instr[11:8], 1'b0};
      end
`ifdef IMM_GEN_UJ_EN
      7'b0110111, 7'b0010111: begin
        w_fmt   = FMT_U;
        w_imm32 = {w_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt   = FMT_J;
        w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                   w_instr[20], w_instr[30:21], 1'b0};
      end
`endif
      7'b0110011, 7'b0111011: begin
        w_fmt = FMT_NONE;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm    = XLEN'($signed(w_imm32));
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_drain  = r_out_valid & bus.out_ready;

  // The skid entry is only ever filled while in_ready is low, so with the skid
  // full no new beat can arrive and the only action is to drain into main.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imm          <= '0;
      r_fmt          <= FMT_NONE;
      r_illegal      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= FMT_NONE;
      r_skid_illegal <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_in_ready     <= 1'b1;
      r_cnt          <= '0;
    end else begin
      if (r_skid_valid) begin
        if (w_drain) begin
          r_imm        <= r_skid_imm;
          r_fmt        <= r_skid_fmt;
          r_illegal    <= r_skid_illegal;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end
      end else if (w_accept) begin
        if (!r_out_valid || bus.out_ready) begin
          r_imm       <= w_imm;
          r_fmt       <= w_fmt;
          r_illegal   <= w_illegal;
          r_out_valid <= 1'b1;
        end else begin
          r_skid_imm     <= w_imm;
          r_skid_fmt     <= w_fmt;
          r_skid_illegal <= w_illegal;
          r_skid_valid   <= 1'b1;
          r_in_ready     <= 1'b0;
        end
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_illegal && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_imm     = r_imm;
  assign bus.out_fmt     = r_fmt;
  assign bus.out_illegal = r_illegal;
  assign illegal_cnt     = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: self-checking bench for imm_gen_pipe (XLEN=64, CNT_W=2).
// Reference: the block is modelled as an ordered queue of at most two decoded
// beats plus an integer illegal counter; immediates are computed arithmetically
// from the instruction fields.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } beat_t;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];
  int    cnt_ref = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t ref_decode(input logic [31:0] w);
    beat_t  b;
    longint s;
    b = '0;
    s = longint'($signed(w));
    case (w[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        b.fmt = 3'd1;
        b.imm = s >>> 20;
      end
      7'h23: begin
        b.fmt = 3'd2;
        b.imm = (s >>> 25) * 32 + longint'(w[11:7]);
      end
      7'h63: begin
        b.fmt = 3'd3;
        b.imm = (w[31] ? -64'sd4096 : 64'sd0) + 2048 * longint'(w[7])
              + 32 * longint'(w[30:25]) + 2 * longint'(w[11:8]);
      end
`ifdef IMM_GEN_UJ_EN
      7'h37, 7'h17: begin
        b.fmt = 3'd4;
        b.imm = longint'($signed(w & 32'hFFFF_F000));
      end
      7'h6F: begin
        b.fmt = 3'd5;
        b.imm = (w[31] ? -64'sd1048576 : 64'sd0) + 4096 * longint'(w[19:12])
              + 2048 * longint'(w[20]) + 2 * longint'(w[30:21]);
      end
`endif
      7'h33, 7'h3B: ;
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  task automatic compare_outputs();
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() > 0});
    check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_ref));
    if (q.size() > 0) begin
      check("out_imm", bus.out_imm, q[0].imm);
      check("out_fmt", 64'(bus.out_fmt), 64'(q[0].fmt));
      check("out_illegal", {63'd0, bus.out_illegal}, {63'd0, q[0].ill});
    end
  endtask

  // Drive one cycle from a falling edge, advance the model across the rising
  // edge, then check outputs at the next falling edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, output logic acc);
    logic drn;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (reset) begin
      q.delete();
      cnt_ref = 0;
      acc = 1'b0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        beat_t b;
        b = ref_decode(ins);
        q.push_back(b);
        if (b.ill && cnt_ref < CNT_MAX) cnt_ref++;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    logic acc;
    reset = 1'b1;
    step(1'b1, 32'h0000_007F, 1'b0, acc);
    check("rst_out_imm", bus.out_imm, 64'd0);
    check("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("rst_out_illegal", {63'd0, bus.out_illegal}, 64'd0);
    reset = 1'b0;
  endtask

  logic [6:0] ops [15] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h0F, 7'h73};

  initial begin
    logic        acc;
    logic [31:0] bp [4];
    int          idx;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    do_reset();

    // Load, then store and branch back-to-back, then lui.
    step(1'b1, 32'hFF81_3283, 1'b1, acc);
    check("ld_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b1, 32'h0051_2623, 1'b1, acc);
    check("sw_imm", bus.out_imm, 64'h0000_0000_0000_000C);
    step(1'b1, 32'hFE00_0EE3, 1'b1, acc);
    check("beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h1234_50B7, 1'b1, acc);
`ifdef IMM_GEN_UJ_EN
    check("lui_imm", bus.out_imm, 64'h0000_0000_1234_5000);
`else
    check("lui_illegal", {63'd0, bus.out_illegal}, 64'd1);
    check("lui_cnt", 64'(illegal_cnt), 64'd1);
`endif
    step(1'b0, '0, 1'b1, acc);

    // Back-pressure: 4 beats, consumer stalled for the first 3 cycles.
    do_reset();
    bp = '{32'h0010_0093, 32'h0051_2623, 32'hFE00_0EE3, 32'hFF81_3283};
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step(1'b1, bp[idx], (c >= 3), acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd4);
    for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, acc);

    // Illegal counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0000_007F, 1'b1, acc);
      check("sat_cnt", 64'(illegal_cnt), 64'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
      check("sat_imm", bus.out_imm, 64'd0);
    end
    step(1'b0, '0, 1'b1, acc);

    // Reset with both registers full, then a clean beat.
    step(1'b1, 32'h0000_007F, 1'b0, acc);
    step(1'b1, 32'h0051_2623, 1'b0, acc);
    check("full_before_rst", {63'd0, bus.in_ready}, 64'd0);
    do_reset();
    step(1'b1, 32'hFF81_3283, 1'b1, acc);
    check("post_rst_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b0, '0, 1'b1, acc);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] w;
      w = $urandom();
      w[6:0] = ops[$urandom_range(14, 0)];
      if ($urandom_range(9, 0) == 0) w[6:0] = 7'($urandom());
      step(($urandom_range(3, 0) != 0), w, ($urandom_range(9, 0) < 7), acc);
      if (c == 1000) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extractor.
- Accepts one 32-bit RV instruction per cycle over a valid/ready handshake and decodes its format.
- Emits the sign-extended XLEN-bit immediate with format tag and illegal flag; keeps a saturating illegal-opcode counter.
- Sits between instruction fetch/IR and the decode/ALU operand mux; tolerates back-pressure from decode without loss.

Parameters:
- XLEN, 64, immediate output width; legal values 32 or 64; all sign extension fills to XLEN.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction beat valid.
- in_ready  output  1  block can accept a beat.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- out_illegal  output  1  opcode not recognised.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal beats.

Behaviour:
- One clock; reset is synchronous and active-high; all state is cleared on a clk edge with reset=1.
- Reset values: in_ready=1 (from the cycle after reset), out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0. Reset mid-operation discards both held beats.
- Decode is combinational on in_instr, indexed by opcode in_instr[6:0].
  - I: 0000011, 0010011, 0011011, 1100111; imm = sext(instr[31:20]).
  - S: 0100011; imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). This is a byte offset with bit0 = 0.
  - U: 0110111, 0010111; imm = sext({instr[31:12], 12'b0}).
  - J: 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - NONE: 0110011, 0111011 (R-type); imm = 0, illegal = 0.
  - Any other opcode: imm = 0, fmt = 0, illegal = 1.
- Pipeline: a main output register plus a one-entry skid register.
  - Latency is exactly 1 cycle from acceptance (in_valid & in_ready) to out_valid when not stalled.
  - Throughput is 1 beat/cycle while out_ready=1.
- in_ready is registered: in_ready = !skid_valid.
- Output is stalled (out_valid=1, out_ready=0): the accepted beat goes to skid; in_ready drops next cycle.
- out_valid & out_ready with skid_valid: skid moves to the main register and in_ready rises next cycle.
- Simultaneous accept and drain with skid empty: the new beat replaces the main register.
- Order is always preserved, with no duplication or loss.
- out_* is stable while out_valid=1 and out_ready=0.
- illegal_cnt increments by 1 on the cycle an illegal beat is accepted at the input. It saturates at 2^CNT_W-1 and does not wrap.

Optional Feature:
- Macro IMM_GEN_UJ_EN.
- Defined: U and J formats are decoded as listed above.
- Undefined: opcodes 0110111, 0010111 and 1101111 are treated as illegal (imm = 0, fmt = 0, illegal = 1, counted). Only the I, S and B formats are recognised.

Test Plan:
- Load: in_instr=0xFF813283 (ld x5,-8(x2)), out_ready=1. Next cycle: out_imm=0xFFFFFFFFFFFFFFF8, fmt=1, illegal=0.
- Store and branch, back-to-back:
  - 0x00512623 (sw x5,12(x2)) gives imm=0x000000000000000C, fmt=2.
  - 0xFE000EE3 (beq x0,x0,-4) gives imm=0xFFFFFFFFFFFFFFFC, fmt=3.
  - The two results appear on consecutive cycles.
- U-type: 0x123450B7 (lui x1,0x12345) gives imm=0x0000000012345000, fmt=4 with IMM_GEN_UJ_EN. Without the macro: illegal=1 and illegal_cnt=1.
- Back-pressure:
  - Stimulus: stream 4 beats; out_ready=0 for 3 cycles after the first beat is presented.
  - in_ready=0 after 2 beats are held.
  - On out_ready=1 all 4 beats emerge in order, with no drops or duplicates.
- Illegal saturation: CNT_W=2, present 0x0000007F five times. Expect illegal_cnt 1, 2, 3, 3, 3; each beat has out_illegal=1 and imm=0.
- Reset mid-operation: assert reset with both registers full. Next cycle: out_valid=0, in_ready=1, illegal_cnt=0. The first beat after reset decodes correctly.
